// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, imem request/ready handshake, decode slot, redirects.
// Optional build macro PC_ALIGN_CHECK_EN traps misaligned redirect targets in a sticky fault.
module pc_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [ADDR_W-1:0] pc_plus4_in,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              align_fault
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, ipc, ipc_n, pend, pend_n;
    logic [31:0]       instr, instr_n;
    logic              vld, vld_n, kill, kill_n, fault, fault_n;

    logic              redir, redir_ok, fault_hit, req, done;
    logic [ADDR_W-1:0] tgt_raw, tgt;

    assign redir   = jump | branch_taken;
    assign tgt_raw = jump ? jump_target : branch_target;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt       = tgt_raw;
    assign fault_hit = redir & ~fault & (|tgt_raw[1:0]);
    assign redir_ok  = redir & ~fault & ~(|tgt_raw[1:0]);
`else
    assign tgt       = tgt_raw & ~(ADDR_W'(3));
    assign fault_hit = 1'b0;
    assign redir_ok  = redir;
`endif

    // Never request while the slot is full and decode is stalled.
    assign req  = (state == FETCH) & ~(vld & stall) & ~fault;
    assign done = req & imem_ready;

    assign pc_out      = pc;
    assign imem_addr   = pc;
    assign imem_req    = req;
    assign if_valid    = vld;
    assign if_instr    = instr;
    assign if_pc       = ipc;
    assign align_fault = fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            vld   <= 1'b0;
            instr <= '0;
            ipc   <= '0;
            kill  <= 1'b0;
            pend  <= '0;
            fault <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            vld   <= vld_n;
            instr <= instr_n;
            ipc   <= ipc_n;
            kill  <= kill_n;
            pend  <= pend_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        vld_n   = vld & stall;
        instr_n = instr;
        ipc_n   = ipc;
        kill_n  = kill;
        pend_n  = pend;
        fault_n = fault;
        if (fault_hit) begin
            vld_n   = 1'b0;
            kill_n  = 1'b0;
            state_n = HOLD;
            fault_n = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_n = FETCH;
                    if (redir_ok) begin
                        pc_n  = tgt;
                        vld_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (fault) begin
                        state_n = HOLD;
                    end else if (redir_ok) begin
                        pc_n    = tgt;
                        vld_n   = 1'b0;
                        state_n = FETCH;
                    end else if (!stall) begin
                        state_n = FETCH;
                    end
                end
                FETCH: begin
                    if (done) begin
                        // A response for a redirected-away address is dropped.
                        if (kill | redir_ok) begin
                            pc_n   = redir_ok ? tgt : pend;
                            vld_n  = 1'b0;
                            kill_n = 1'b0;
                        end else begin
                            instr_n = imem_rdata;
                            ipc_n   = pc;
                            vld_n   = 1'b1;
                            pc_n    = pc_plus4_in;
                        end
                    end else if (req) begin
                        // Keep imem_addr stable; apply the target once ready arrives.
                        if (redir_ok) begin
                            pend_n = tgt;
                            kill_n = 1'b1;
                            vld_n  = 1'b0;
                        end
                    end else if (redir_ok) begin
                        pc_n  = tgt;
                        vld_n = 1'b0;
                    end else begin
                        state_n = HOLD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios plus a randomized run against a control-flow model.
module tb_pc_fetch_stage;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_out, pc_plus4_in, branch_target, jump_target, imem_addr, imem_rdata, if_instr, if_pc;
    logic        branch_taken, jump, stall, imem_req, imem_ready, if_valid, align_fault;

    int total = 0, bad = 0;
    int waits = 0, wcnt = 0;
    logic        pre_req, pre_rdy;
    logic [31:0] pre_addr;

    pc_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .pc_plus4_in(pc_plus4_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .align_fault(align_fault)
    );

    always #5 clk = ~clk;
    assign pc_plus4_in = pc_out + 32'd4;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Memory responder: ready after 'waits' cycles of continuous request.
    task automatic settle();
        #1;
        imem_ready = imem_req && (wcnt >= waits);
        imem_rdata = imem_ready ? memf(imem_addr) : 32'hDEAD_BEEF;
        #1;
        pre_req = imem_req; pre_rdy = imem_ready; pre_addr = imem_addr;
    endtask

    task automatic clk_tick();
        @(posedge clk);
        if (pre_req && !pre_rdy) wcnt++; else wcnt = 0;
        @(negedge clk);
    endtask

    task automatic step();
        settle(); clk_tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 0; jump = 0; branch_taken = 0;
        jump_target = 0; branch_target = 0; imem_ready = 0; imem_rdata = 0;
        waits = 0; wcnt = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; jump = 0; branch_taken = 0;
        jump_target = 0; branch_target = 0; imem_ready = 0; imem_rdata = 0; waits = 0; wcnt = 0;
        @(negedge clk); #1;
        total += 7;
        if (pc_out !== 32'h0)      begin bad++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        if (imem_req !== 1'b0)     begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        if (imem_addr !== 32'h0)   begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        if (if_valid !== 1'b0)     begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        if (if_instr !== 32'h0)    begin bad++; $display("FAIL reset_instr: got %h want 0", if_instr); end
        if (if_pc !== 32'h0)       begin bad++; $display("FAIL reset_ifpc: got %h want 0", if_pc); end
        if (align_fault !== 1'b0)  begin bad++; $display("FAIL reset_fault: got %b want 0", align_fault); end
        @(negedge clk); rst_n = 1'b1;
        settle(); total++;
        if (pre_req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", pre_req); end
        clk_tick();
        settle(); total++;
        if (pre_req !== 1'b1 || pre_addr !== 32'h0) begin bad++; $display("FAIL first_req: got %b/%h want 1/0", pre_req, pre_addr); end
        clk_tick();
        total++;
        if (if_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", if_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset(); waits = 3;
        step(); settle();
        rst_n = 1'b0; #1; total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin bad++; $display("FAIL reset_mid: got req=%b vld=%b want 0/0", imem_req, if_valid); end
        @(negedge clk); rst_n = 1'b1; wcnt = 0;
    endtask

    task automatic test_seq();
        do_reset(); step();
        for (int i = 0; i < 4; i++) begin
            settle(); total++;
            if (pre_addr !== 32'(4*i) || !pre_req || !pre_rdy) begin bad++; $display("FAIL seq_addr: got %h want %h", pre_addr, 32'(4*i)); end
            clk_tick(); total++;
            if (!if_valid || if_pc !== 32'(4*i) || if_instr !== memf(32'(4*i)))
                begin bad++; $display("FAIL seq_data: got %b/%h/%h want 1/%h/%h", if_valid, if_pc, if_instr, 32'(4*i), memf(32'(4*i))); end
        end
    endtask

    task automatic test_wait();
        do_reset(); waits = 3; step();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                settle(); total++;
                if (!pre_req || pre_addr !== 32'(4*f) || if_valid !== (f == 1 && k == 0))
                    begin bad++; $display("FAIL wait_hold: got req=%b addr=%h vld=%b at f%0d k%0d", pre_req, pre_addr, if_valid, f, k); end
                clk_tick();
            end
            total++;
            if (!if_valid || if_pc !== 32'(4*f)) begin bad++; $display("FAIL wait_valid: got %b/%h want 1/%h", if_valid, if_pc, 32'(4*f)); end
        end
    endtask

    task automatic test_stall();
        do_reset(); step(); step(); step(); step();
        total++;
        if (!if_valid || if_pc !== 32'h8) begin bad++; $display("FAIL stall_pre: got %b/%h want 1/8", if_valid, if_pc); end
        stall = 1;
        for (int k = 0; k < 5; k++) begin
            settle(); total++;
            if (pre_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", pre_req); end
            clk_tick(); total++;
            if (!if_valid || if_pc !== 32'h8 || if_instr !== memf(32'h8)) begin bad++; $display("FAIL stall_frozen: got %b/%h/%h want 1/8", if_valid, if_pc, if_instr); end
        end
        stall = 0;
        settle(); total++;
        if (pre_req !== 1'b0) begin bad++; $display("FAIL hold_exit_req: got %b want 0", pre_req); end
        clk_tick(); total++;
        if (if_valid !== 1'b0) begin bad++; $display("FAIL hold_consume: got %b want 0", if_valid); end
        settle(); total++;
        if (!pre_req || pre_addr !== 32'hC) begin bad++; $display("FAIL resume_addr: got %b/%h want 1/c", pre_req, pre_addr); end
        clk_tick(); total++;
        if (!if_valid || if_pc !== 32'hC) begin bad++; $display("FAIL resume_data: got %b/%h want 1/c", if_valid, if_pc); end
    endtask

    task automatic test_branch_wait();
        do_reset(); jump = 1; jump_target = 32'h10; step(); jump = 0;
        waits = 3;
        for (int k = 0; k < 4; k++) begin
            branch_taken = (k == 1); branch_target = 32'h100;
            settle(); total++;
            if (!pre_req || pre_addr !== 32'h10) begin bad++; $display("FAIL kill_addr: got %b/%h want 1/10", pre_req, pre_addr); end
            clk_tick(); total++;
            if (if_valid !== 1'b0) begin bad++; $display("FAIL kill_valid: got %b want 0", if_valid); end
        end
        branch_taken = 0; total++;
        if (imem_addr !== 32'h100) begin bad++; $display("FAIL kill_target: got %h want 100", imem_addr); end
        for (int k = 0; k < 4; k++) step();
        total++;
        if (!if_valid || if_pc !== 32'h100 || if_instr !== memf(32'h100)) begin bad++; $display("FAIL kill_after: got %b/%h want 1/100", if_valid, if_pc); end
    endtask

    task automatic test_jump_branch();
        do_reset(); step(); step();
        stall = 1; step();
        jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
        step(); jump = 0; branch_taken = 0; total++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h200) begin bad++; $display("FAIL prio: got vld=%b addr=%h want 0/200", if_valid, imem_addr); end
        settle(); total++;
        if (pre_req !== 1'b1) begin bad++; $display("FAIL prio_req: got %b want 1", pre_req); end
        clk_tick(); total++;
        if (!if_valid || if_pc !== 32'h200) begin bad++; $display("FAIL prio_data: got %b/%h want 1/200", if_valid, if_pc); end
        stall = 0;
    endtask

    task automatic test_misalign();
        do_reset(); step(); step();
        jump = 1; jump_target = 32'h102; step(); jump = 0;
`ifdef PC_ALIGN_CHECK_EN
        total++;
        if (align_fault !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin bad++; $display("FAIL fault_set: got %b/%h/%b want 1/4/0", align_fault, imem_addr, if_valid); end
        for (int k = 0; k < 3; k++) begin
            jump = (k == 1); jump_target = 32'h40;
            settle(); total++;
            if (pre_req !== 1'b0) begin bad++; $display("FAIL fault_req: got %b want 0", pre_req); end
            clk_tick(); total++;
            if (align_fault !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL fault_sticky: got %b/%h want 1/4", align_fault, imem_addr); end
        end
        jump = 0;
`else
        total++;
        if (align_fault !== 1'b0 || imem_addr !== 32'h100) begin bad++; $display("FAIL mask: got %b/%h want 0/100", align_fault, imem_addr); end
        step(); total++;
        if (!if_valid || if_pc !== 32'h100) begin bad++; $display("FAIL mask_data: got %b/%h want 1/100", if_valid, if_pc); end
`endif
    endtask

    task automatic test_wrap();
        do_reset(); jump = 1; jump_target = 32'hFFFF_FFFC; step(); jump = 0;
        step(); total++;
        if (if_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin bad++; $display("FAIL wrap: got %h/%h want fffffffc/0", if_pc, imem_addr); end
        step(); total++;
        if (!if_valid || if_pc !== 32'h0) begin bad++; $display("FAIL wrap_next: got %b/%h want 1/0", if_valid, if_pc); end
    endtask

    // Model: delivered instructions follow sequential flow from the last redirect target;
    // responses for requests overtaken by a redirect never reach decode.
    task automatic test_random();
        logic [31:0] exp_fetch, m_pc, m_ins, last_addr, tgt;
        logic        stale, last_pend, redir, good, pv;
        do_reset();
        exp_fetch = 0; m_pc = 0; m_ins = 0; last_addr = 0; stale = 0; last_pend = 0;
        for (int c = 0; c < 3000; c++) begin
            stall         = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 15) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            jump_target   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 1023));
            branch_target = 32'($urandom_range(0, 1023));
`ifdef PC_ALIGN_CHECK_EN
            jump_target   = jump_target & ~32'd3;
            branch_target = branch_target & ~32'd3;
`endif
            if (wcnt == 0) waits = $urandom_range(0, 2);
            settle();
            if (last_pend && pre_req) begin
                total++;
                if (pre_addr !== last_addr) begin bad++; $display("FAIL rnd_addr_stable: got %h want %h", pre_addr, last_addr); end
            end
            if (if_valid && stall) begin
                total++;
                if (pre_req !== 1'b0) begin bad++; $display("FAIL rnd_req_full: got %b want 0", pre_req); end
            end
            redir = jump | branch_taken;
            tgt   = (jump ? jump_target : branch_target) & ~32'd3;
            good  = pre_req && pre_rdy && !stale && !redir;
            if (good) begin
                total++;
                if (pre_addr !== exp_fetch) begin bad++; $display("FAIL rnd_fetch_addr: got %h want %h", pre_addr, exp_fetch); end
                m_pc = exp_fetch; m_ins = memf(exp_fetch); exp_fetch = exp_fetch + 32'd4;
            end
            pv = !redir && (good || (if_valid && stall));
            if (redir) begin
                stale = pre_req && !pre_rdy; exp_fetch = tgt;
            end else if (pre_req && pre_rdy) begin
                stale = 0;
            end
            last_pend = pre_req && !pre_rdy; last_addr = pre_addr;
            clk_tick();
            total++;
            if (if_valid !== pv) begin bad++; $display("FAIL rnd_valid: got %b want %b cycle %0d", if_valid, pv, c); end
            if (pv) begin
                total++;
                if (if_pc !== m_pc || if_instr !== m_ins) begin bad++; $display("FAIL rnd_slot: got %h/%h want %h/%h", if_pc, if_instr, m_pc, m_ins); end
            end
        end
        stall = 0; jump = 0; branch_taken = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_reset_mid();
        test_seq();
        test_wait();
        test_stall();
        test_branch_wait();
        test_jump_branch();
        test_misalign();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
